ctrl_pipe_unit: RTL and testbench
=================================

Name: ctrl_pipe_unit

Overview:
- Pipelined successor of the single-cycle opcode decoder in the RISC-V CPU.
- Decodes the ID-stage opcode into the control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Owns load-use hazard detection (stall/bubble), ID-stage bubble insertion and EX-stage forwarding select.
- Sits between the IF/ID register and the datapath pipeline registers; the datapath carries only data.

Parameters:
- REG_AW, 5, register-index width (rs1/rs2/rd).
- OP_W, 7, opcode width.
- ALUOP_W, 2, ALUOp field width; MSBs above bit 1 are always driven 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- op_i  in  OP_W  ID-stage opcode.
- rs1_i  in  REG_AW  ID-stage rs1 index.
- rs2_i  in  REG_AW  ID-stage rs2 index.
- rd_i  in  REG_AW  ID-stage rd index.
- no_op_i  in  1  external bubble request for the ID instruction.
- stall_o  out  1  load-use stall: hold PC and IF/ID.
- branch_o  out  1  ID-stage beq decode, combinational.
- ex_aluop_o  out  ALUOP_W  ID/EX ALUOp.
- ex_alusrc_o  out  1  ID/EX ALUSrc.
- ex_rs1_o, ex_rs2_o  out  REG_AW  ID/EX source indices.
- fwd_a_o, fwd_b_o  out  2  EX operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- mem_memread_o, mem_memwrite_o  out  1  EX/MEM memory controls.
- wb_regwrite_o, wb_memtoreg_o  out  1  MEM/WB writeback controls.
- wb_rd_o  out  REG_AW  MEM/WB destination index.

Behaviour:
- Decode (combinational). Columns are ALUOp / ALUSrc / RegWrite / MemRead / MemWrite / MemtoReg / Branch.
  - 0010011 addi: 11 / 1 / 1 / 0 / 0 / 0 / 0
  - 0110011 R-type: 10 / 0 / 1 / 0 / 0 / 0 / 0
  - 0000011 lw: 00 / 1 / 1 / 1 / 0 / 1 / 0
  - 0100011 sw: 00 / 1 / 0 / 0 / 1 / 0 / 0
  - 1100011 beq: 01 / 0 / 0 / 0 / 0 / 0 / 1
  - Any other opcode, including 0000000: all-zero bundle (bubble).
- Load-use hazard:
  - stall_o = ID/EX MemRead && ID/EX rd != 0 && (ID/EX rd == rs1_i || ID/EX rd == rs2_i).
  - Combinational from current register state.
- Bubble: if stall_o or no_op_i, the decoded bundle is forced all-zero before ID/EX capture.
  - branch_o = decoded Branch && !stall_o && !no_op_i. A stalled branch re-decodes next cycle.
- Register advance on every clock edge, no enable:
  - ID/EX <= bubble-masked bundle + rs1/rs2/rd.
  - EX/MEM <= RegWrite/MemtoReg/MemRead/MemWrite/rd from ID/EX.
  - MEM/WB <= RegWrite/MemtoReg/rd from EX/MEM.
- Latency: a decoded instruction appears on the ex_* outputs 1 cycle after ID, on mem_* after 2, on wb_* after 3.
- Forwarding (combinational on register state), A path (B path identical with ex_rs2):
  - 10 if EX/MEM RegWrite && EX/MEM rd != 0 && EX/MEM rd == ex_rs1_o.
  - else 01 if MEM/WB RegWrite && MEM/WB rd != 0 && MEM/WB rd == ex_rs1_o.
  - else 00.
  - EX/MEM wins when both match.
- x0 never stalls and is never forwarded.
- Reset:
  - On a clock edge with rst_i = 0, all three pipeline registers clear to zero.
  - All registered outputs therefore read 0, fwd_* read 00 and stall_o reads 0 by the next cycle.
  - Reset applied mid-stall drops the stall in the following cycle. The ID instruction is then re-decoded normally.
- Simultaneous stall_o and no_op_i: a single bubble is inserted; no extra effect.
- Back-to-back lw followed by a dependent instruction: exactly one stall cycle. The second cycle sees a bubble in ID/EX, so stall_o = 0.

Optional Feature:
- Macro: CTRL_ILLEGAL_OP_EN.
- Defined:
  - Adds output illegal_o (1 bit), sticky, registered.
  - Sets on the edge after an opcode outside the five decoded ones and outside 0000000 is decoded while !stall_o && !no_op_i.
  - Clears only on reset.
  - The instruction itself still becomes a bubble.
- Undefined: port absent; unknown opcodes silently become bubbles.

Test Plan:
- Reset: rst_i = 0 for 2 cycles with op_i = 0110011 -> all ex_/mem_/wb_ outputs 0, stall_o = 0, fwd_* = 00. Release -> ex_aluop_o = 10 one cycle later.
- Load-use: lw rd = 5, then add rs1 = 5 -> stall_o = 1 for exactly 1 cycle. ID/EX holds the bubble (ex_aluop_o = 00, ex_alusrc_o = 0). The add enters EX next cycle with fwd_a_o = 01.
- Forwarding priority: add rd = 3; add rd = 3; add rs1 = 3, rs2 = 3 -> third instruction in EX sees fwd_a_o = fwd_b_o = 10. With one unrelated instruction in between -> 01.
- x0: lw rd = 0 then add rs1 = 0 -> stall_o = 0 and fwd_a_o = 00.
- Branch/no_op: beq with no_op_i = 1 -> branch_o = 0 and an all-zero ID/EX. beq stalled behind lw rd = 6 / rs1 = 6 -> branch_o = 0 in the stall cycle, 1 in the next.
- CTRL_ILLEGAL_OP_EN: op_i = 1111111 -> illegal_o = 1 the next cycle and stays 1 through valid ops until rst_i = 0. Without the macro -> the same op yields an all-zero bundle.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: pipelined control decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall/bubble and EX forwarding select.
// Ports: clk_i, rst_i (sync, active-low); ID inputs op_i/rs1_i/rs2_i/rd_i,
// no_op_i; outputs stall_o, branch_o, ex_*, fwd_a_o/fwd_b_o, mem_*, wb_*.
// Optional macro CTRL_ILLEGAL_OP_EN adds sticky illegal_o.
module ctrl_pipe_unit #(
  parameter int REG_AW  = 5,
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_AW-1:0]  rs1_i,
  input  logic [REG_AW-1:0]  rs2_i,
  input  logic [REG_AW-1:0]  rd_i,
  input  logic               no_op_i,
  output logic               stall_o,
  output logic               branch_o,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic [REG_AW-1:0]  ex_rs1_o,
  output logic [REG_AW-1:0]  ex_rs2_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o,
  output logic               mem_memread_o,
  output logic               mem_memwrite_o,
`ifdef CTRL_ILLEGAL_OP_EN
  output logic               illegal_o,
`endif
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o,
  output logic [REG_AW-1:0]  wb_rd_o
);

  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
  } ctl_t;

  typedef struct packed {
    ctl_t              ctl;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } mem_wb_t;

  ctl_t    dec;
  ctl_t    ctl_in;
  logic    dec_branch;
  logic    known;
  logic    stall;
  logic    bubble;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  always_comb begin
    dec        = '0;
    dec_branch = 1'b0;
    known      = 1'b1;
    unique case (1'b1)
      (op_i == OP_ADDI): dec = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      (op_i == OP_RTYP): dec = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      (op_i == OP_LW):   dec = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      (op_i == OP_SW):   dec = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      (op_i == OP_BEQ): begin
        dec        = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        dec_branch = 1'b1;
      end
      (op_i == '0):      known = 1'b1;
      default:           known = 1'b0;
    endcase
  end

  // Load in EX whose result a source in ID needs: hold and bubble once.
  assign stall = id_ex.ctl.memread && (id_ex.rd != '0) &&
                 ((id_ex.rd == rs1_i) || (id_ex.rd == rs2_i));

  assign bubble   = stall || no_op_i;
  assign ctl_in   = bubble ? '0 : dec;
  assign stall_o  = stall;
  assign branch_o = dec_branch && !bubble;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      id_ex.ctl <= ctl_in;
      id_ex.rs1 <= rs1_i;
      id_ex.rs2 <= rs2_i;
      id_ex.rd  <= rd_i;

      ex_mem.regwrite <= id_ex.ctl.regwrite;
      ex_mem.memtoreg <= id_ex.ctl.memtoreg;
      ex_mem.memread  <= id_ex.ctl.memread;
      ex_mem.memwrite <= id_ex.ctl.memwrite;
      ex_mem.rd       <= id_ex.rd;

      mem_wb.regwrite <= ex_mem.regwrite;
      mem_wb.memtoreg <= ex_mem.memtoreg;
      mem_wb.rd       <= ex_mem.rd;
    end
  end

`ifdef CTRL_ILLEGAL_OP_EN
  logic illegal;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      illegal <= 1'b0;
    end else if (!known && !bubble) begin
      illegal <= 1'b1;
    end
  end

  assign illegal_o = illegal;
`else
  logic unused_known;
  assign unused_known = known;
`endif

  // Newest producer (EX/MEM) wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (ex_mem.regwrite && ex_mem.rd != '0 && ex_mem.rd == src)
      return 2'b10;
    else if (mem_wb.regwrite && mem_wb.rd != '0 && mem_wb.rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign fwd_a_o = fwd_sel(id_ex.rs1);
  assign fwd_b_o = fwd_sel(id_ex.rs2);

  assign ex_aluop_o     = ALUOP_W'(id_ex.ctl.aluop);
  assign ex_alusrc_o    = id_ex.ctl.alusrc;
  assign ex_rs1_o       = id_ex.rs1;
  assign ex_rs2_o       = id_ex.rs2;
  assign mem_memread_o  = ex_mem.memread;
  assign mem_memwrite_o = ex_mem.memwrite;
  assign wb_regwrite_o  = mem_wb.regwrite;
  assign wb_memtoreg_o  = mem_wb.memtoreg;
  assign wb_rd_o        = mem_wb.rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit: directed checks of ctrl_pipe_unit decode, pipeline
// latency, load-use stall, forwarding, bubbles and optional illegal_o.
module tb_ctrl_pipe_unit;

  localparam logic [6:0] NOP  = 7'b0000000;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] RTYP = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op  = '0;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic [4:0] rd  = '0;
  logic       no_op = 1'b0;
  logic       stall, branch, ex_alusrc;
  logic [1:0] ex_aluop, fwd_a, fwd_b;
  logic [4:0] ex_rs1, ex_rs2, wb_rd;
  logic       mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
`ifdef CTRL_ILLEGAL_OP_EN
  logic       illegal;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_i          (op),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rd_i          (rd),
    .no_op_i       (no_op),
    .stall_o       (stall),
    .branch_o      (branch),
    .ex_aluop_o    (ex_aluop),
    .ex_alusrc_o   (ex_alusrc),
    .ex_rs1_o      (ex_rs1),
    .ex_rs2_o      (ex_rs2),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .mem_memread_o (mem_memread),
    .mem_memwrite_o(mem_memwrite),
`ifdef CTRL_ILLEGAL_OP_EN
    .illegal_o     (illegal),
`endif
    .wb_regwrite_o (wb_regwrite),
    .wb_memtoreg_o (wb_memtoreg),
    .wb_rd_o       (wb_rd)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] o, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d,
                       input logic n);
    op = o; rs1 = a; rs2 = b; rd = d; no_op = n;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    issue(NOP, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    // Reset held with an R-type in ID
    issue(RTYP, 1, 2, 7, 0);
    repeat (2) tick();
    chk("rst_aluop", 8'(ex_aluop), 0);
    chk("rst_alusrc", 8'(ex_alusrc), 0);
    chk("rst_rs1", 8'(ex_rs1), 0);
    chk("rst_mem", 8'({mem_memread, mem_memwrite}), 0);
    chk("rst_wb", 8'({wb_regwrite, wb_memtoreg, wb_rd}), 0);
    chk("rst_stall", 8'(stall), 0);
    chk("rst_fwd", 8'({fwd_a, fwd_b}), 0);
`ifdef CTRL_ILLEGAL_OP_EN
    chk("rst_illegal", 8'(illegal), 0);
`endif
    rst = 1'b1;
    tick();
    chk("rel_aluop", 8'(ex_aluop), 8'b10);

    // Decode/latency for lw, sw, addi
    flush();
    issue(LW, 1, 0, 4, 0);
    tick();
    issue(SW, 2, 3, 0, 0);
    chk("lw_ex", 8'({ex_aluop, ex_alusrc}), 8'b001);
    tick();
    issue(ADDI, 1, 0, 9, 0);
    chk("lw_mem", 8'({mem_memread, mem_memwrite}), 8'b10);
    chk("sw_ex", 8'({ex_aluop, ex_alusrc}), 8'b001);
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("lw_wb", 8'({wb_regwrite, wb_memtoreg, wb_rd}), 8'b1_1_00100);
    chk("sw_mem", 8'({mem_memread, mem_memwrite}), 8'b01);
    chk("addi_ex", 8'({ex_aluop, ex_alusrc}), 8'b111);
    tick();
    chk("sw_wb", 8'({wb_regwrite, wb_memtoreg}), 0);

    // Load-use: lw x5 then add rs1=x5
    flush();
    issue(LW, 0, 0, 5, 0);
    chk("lu_nostall", 8'(stall), 0);
    tick();
    issue(RTYP, 5, 0, 8, 0);
    chk("lu_stall", 8'(stall), 1);
    tick();
    chk("lu_bub_ex", 8'({ex_aluop, ex_alusrc}), 0);
    chk("lu_stall_drop", 8'(stall), 0);
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("lu_add_ex", 8'(ex_aluop), 8'b10);
    chk("lu_fwd_a", 8'(fwd_a), 8'b01);
    chk("lu_fwd_b", 8'(fwd_b), 8'b00);
    chk("lu_wb_rd", 8'(wb_rd), 5);

    // Forwarding priority: two producers of x3
    flush();
    issue(RTYP, 1, 2, 3, 0);
    tick();
    tick();
    issue(RTYP, 3, 3, 4, 0);
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("fwd_pri_a", 8'(fwd_a), 8'b10);
    chk("fwd_pri_b", 8'(fwd_b), 8'b10);

    // One unrelated instruction in between
    flush();
    issue(RTYP, 1, 2, 3, 0);
    tick();
    issue(ADDI, 1, 0, 9, 0);
    tick();
    issue(RTYP, 3, 3, 4, 0);
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("fwd_wb_a", 8'(fwd_a), 8'b01);
    chk("fwd_wb_b", 8'(fwd_b), 8'b01);

    // x0 neither stalls nor forwards
    flush();
    issue(LW, 0, 0, 0, 0);
    tick();
    issue(RTYP, 0, 0, 1, 0);
    chk("x0_stall", 8'(stall), 0);
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("x0_fwd", 8'({fwd_a, fwd_b}), 0);

    // Branch with external bubble, then unmasked
    flush();
    issue(BEQ, 1, 2, 0, 1);
    chk("beq_noop_br", 8'(branch), 0);
    tick();
    chk("beq_noop_ex", 8'({ex_aluop, ex_alusrc}), 0);
    chk("beq_noop_rs1", 8'(ex_rs1), 1);
    issue(BEQ, 1, 2, 0, 0);
    chk("beq_br", 8'(branch), 1);

    // Branch stalled behind a load
    flush();
    issue(LW, 0, 0, 6, 0);
    tick();
    issue(BEQ, 6, 0, 0, 0);
    chk("beqst_stall", 8'(stall), 1);
    chk("beqst_br0", 8'(branch), 0);
    tick();
    chk("beqst_stall0", 8'(stall), 0);
    chk("beqst_br1", 8'(branch), 1);
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("beqst_ex", 8'(ex_aluop), 8'b01);

    // Stall and no_op together: one bubble only
    flush();
    issue(LW, 0, 0, 6, 0);
    tick();
    issue(RTYP, 6, 0, 2, 1);
    chk("both_stall", 8'(stall), 1);
    chk("both_br", 8'(branch), 0);
    tick();
    chk("both_bub", 8'(ex_aluop), 0);
    chk("both_stall0", 8'(stall), 0);

    // Reset applied mid-stall
    flush();
    issue(LW, 0, 0, 5, 0);
    tick();
    issue(RTYP, 5, 0, 8, 0);
    rst = 1'b0;
    #1;
    chk("rs_stall", 8'(stall), 1);
    tick();
    chk("rs_drop", 8'(stall), 0);
    chk("rs_ex", 8'({ex_aluop, ex_alusrc}), 0);
    rst = 1'b1;
    tick();
    chk("rs_redecode", 8'(ex_aluop), 8'b10);

    // Unknown opcode becomes a bubble
    flush();
    issue(BAD, 1, 2, 9, 0);
    chk("bad_br", 8'(branch), 0);
    tick();
    issue(RTYP, 1, 2, 3, 0);
    chk("bad_ex", 8'({ex_aluop, ex_alusrc}), 0);
`ifdef CTRL_ILLEGAL_OP_EN
    chk("ill_set", 8'(illegal), 1);
`endif
    tick();
    issue(NOP, 0, 0, 0, 0);
    chk("bad_mem", 8'({mem_memread, mem_memwrite}), 0);
    chk("post_bad_ex", 8'(ex_aluop), 8'b10);
`ifdef CTRL_ILLEGAL_OP_EN
    chk("ill_sticky", 8'(illegal), 1);
    tick();
    chk("ill_sticky2", 8'(illegal), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("ill_clr", 8'(illegal), 0);
    issue(BAD, 0, 0, 0, 1);
    tick();
    chk("ill_noop", 8'(illegal), 0);
`endif
    tick();
    chk("bad_wb", 8'(wb_regwrite), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
